uart_wb_host: RTL and testbench

//  Wishbone classic initiator that drives the UART CSR slave at 0x3000_00xx from the master side.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_host_fifo.sv | 61 ++++++
 rtl/uart_wb_host.sv | 203 ++++++++++++++++++++
 tb/tb_uart_wb_host.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART CSR block and its Wishbone host.
//  - default CSR addresses of the UART slave
//  - STATUS bit that reads 1 while the transmitter is busy
//  - host FSM state encoding
package uart_pkg;

    localparam logic [31:0] UART_RX_ADDR     = 32'h3000_0000;
    localparam logic [31:0] UART_TX_ADDR     = 32'h3000_0004;
    localparam logic [31:0] UART_STAT_ADDR   = 32'h3000_0008;
    localparam int unsigned UART_TX_BUSY_BIT = 5;

    typedef enum logic [2:0] {
        StIdle,
        StRdRx,
        StWrTx,
        StPoll,
        StGap
    } host_state_e;

endpackage

// File: rtl/uart_host_fifo.sv
// Small circular byte buffer for RX data.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full. A push is accepted while full when a
// pop happens in the same cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   push_data    byte to store
//   pop          drop the head entry (ignored when empty)
//   head         current head entry, meaningful only while !empty
//   full, empty  occupancy flags
module uart_host_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_wb_host.sv
// Wishbone classic initiator that services a UART CSR slave.
// An irq pulse schedules a read of RX_DATA into a small RX buffer; each TX byte
// is written to TX_DATA and STATUS is then polled (with an idle gap between
// polls) until the transmitter reports idle. Unacknowledged transfers are
// aborted after TIMEOUT cycles and flagged on the sticky err_o.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   wbm_cyc_o/stb_o/we_o/sel_o   Wishbone control (stb mirrors cyc)
//   wbm_adr_o/dat_o/dat_i/ack_i  Wishbone address/data/acknowledge
//   irq_i                        UART irq pulse, requests an RX read
//   tx_valid_i/tx_data_i/tx_ready_o   TX byte stream in
//   rx_valid_o/rx_data_o/rx_ready_i   RX byte stream out
//   err_o                        sticky ack-timeout flag
module uart_wb_host
    import uart_pkg::*;
#(
    parameter logic [31:0] RX_ADDR     = UART_RX_ADDR,
    parameter logic [31:0] TX_ADDR     = UART_TX_ADDR,
    parameter logic [31:0] STAT_ADDR   = UART_STAT_ADDR,
    parameter int unsigned TX_BUSY_BIT = UART_TX_BUSY_BIT,
    parameter int unsigned RX_DEPTH    = 4,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned POLL_GAP    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        irq_i,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    input  logic        rx_ready_i,
    output logic        err_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    host_state_e state_q;
    logic        cyc_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [7:0]  tmo_cnt_q;
    logic [7:0]  gap_cnt_q;
    logic        irq_pend_q;
    logic        tx_hold_full_q;
    logic [7:0]  tx_hold_q;
    logic        err_q;

    logic        rx_push;
    logic        rx_pop;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        bus_state;
    logic        start_rx;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        unused_dat;

    // Only the RX byte and the busy bit of the read data are consumed.
    assign unused_dat = ^wbm_dat_i;

    assign bus_state = (state_q == StRdRx) || (state_q == StWrTx) || (state_q == StPoll);
    // A full RX buffer holds the request off, so the irq stays pending.
    assign start_rx  = (state_q == StIdle) && irq_pend_q && !rx_full;
    assign rx_push   = (state_q == StRdRx) && cyc_q && wbm_ack_i;
    assign rx_pop    = rx_ready_i && !rx_empty;

    // Transfer attributes for the bus state about to raise cyc.
    always_comb begin
        req_we  = 1'b0;
        req_sel = 4'hF;
        req_adr = STAT_ADDR;
        req_dat = '0;
        case (state_q)
            StRdRx: req_adr = RX_ADDR;
            StWrTx: begin
                req_adr = TX_ADDR;
                req_we  = 1'b1;
                req_sel = 4'h1;
                req_dat = {24'b0, tx_hold_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cyc_q          <= 1'b0;
            we_q           <= 1'b0;
            sel_q          <= '0;
            adr_q          <= '0;
            dat_q          <= '0;
            tmo_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            irq_pend_q     <= 1'b0;
            tx_hold_full_q <= 1'b0;
            tx_hold_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            // A new irq wins over the clear on entry to RdRx.
            if (irq_i) begin
                irq_pend_q <= 1'b1;
            end else if (start_rx) begin
                irq_pend_q <= 1'b0;
            end

            if (tx_valid_i && !tx_hold_full_q) begin
                tx_hold_q      <= tx_data_i;
                tx_hold_full_q <= 1'b1;
            end

            if (bus_state) begin
                if (!cyc_q) begin
                    cyc_q     <= 1'b1;
                    we_q      <= req_we;
                    sel_q     <= req_sel;
                    adr_q     <= req_adr;
                    dat_q     <= req_dat;
                    tmo_cnt_q <= '0;
                end else if (wbm_ack_i) begin
                    cyc_q <= 1'b0;
                    case (state_q)
                        StWrTx: state_q <= StPoll;
                        StPoll: begin
                            if (wbm_dat_i[TX_BUSY_BIT]) begin
                                state_q   <= StGap;
                                gap_cnt_q <= '0;
                            end else begin
                                tx_hold_full_q <= 1'b0;
                                state_q        <= StIdle;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abort: an RX read is simply lost, a TX byte is dropped.
                    cyc_q   <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= StIdle;
                    if (state_q != StRdRx) begin
                        tx_hold_full_q <= 1'b0;
                    end
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                end
            end else if (state_q == StGap) begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_q <= StPoll;
                end else begin
                    gap_cnt_q <= gap_cnt_q + 8'd1;
                end
            end else begin
                if (start_rx) begin
                    state_q <= StRdRx;
                end else if (tx_hold_full_q) begin
                    state_q <= StWrTx;
                end
            end
        end
    end

    uart_host_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (wbm_dat_i[7:0]),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign tx_ready_o = !tx_hold_full_q;
    assign rx_valid_o = !rx_empty;
    assign rx_data_o  = rx_head;
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_wb_host.sv
// Self-checking bench for uart_wb_host: a behavioural Wishbone UART slave,
// directed sequences for reset/irq/TX/full-buffer/timeout/reset corners, a
// table of TX+RX vectors, and a randomized run checked against byte queues.
module tb_uart_wb_host;

    localparam logic [31:0] A_RX   = 32'h3000_0000;
    localparam logic [31:0] A_TX   = 32'h3000_0004;
    localparam logic [31:0] A_STAT = 32'h3000_0008;
    localparam int          BUSY_BIT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        irq_i, tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, err_o;
    logic [7:0]  tx_data_i, rx_data_o;

    always #5 clk = ~clk;

    uart_wb_host dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .irq_i      (irq_i),
        .tx_valid_i (tx_valid_i),
        .tx_data_i  (tx_data_i),
        .tx_ready_o (tx_ready_o),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o),
        .rx_ready_i (rx_ready_i),
        .err_o      (err_o)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          start;
        bit          stable;
    } txn_t;

    typedef struct {
        logic [7:0] tx;
        int         busy;
        logic [7:0] rx;
    } vec_t;

    txn_t       log_q[$];
    logic [7:0] rxq[$];     // bytes the slave returns for RX reads
    logic [7:0] rx_exp[$];  // bytes the host must deliver, in order
    logic [7:0] tx_exp[$];
    int  busy_left = 0;
    int  busy_next = 0;
    int  ack_delay = 2;
    bit  rand_busy = 1'b0;
    bit  rand_lat  = 1'b0;
    bit  no_ack    = 1'b0;
    int  cycle     = 0;
    int  checks    = 0;
    int  errors    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural UART slave plus bus monitor.
    initial begin
        int          wcnt;
        int          lat;
        logic [31:0] r;
        logic [7:0]  b;
        txn_t        t;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        wcnt = 0;
        lat  = 2;
        t    = '{adr: 0, we: 0, sel: 0, dat: 0, start: 0, stable: 1};
        forever begin
            @(posedge clk);
            #1;
            if (wbm_ack_i) begin
                wbm_ack_i = 1'b0;
                wcnt = 0;
            end else if (wbm_cyc_o) begin
                if (wcnt == 0) begin
                    t.adr = wbm_adr_o; t.we = wbm_we_o; t.sel = wbm_sel_o; t.dat = wbm_dat_o;
                    t.start = cycle; t.stable = (wbm_stb_o == 1'b1);
                    lat = rand_lat ? int'($urandom_range(1, 4)) : ack_delay;
                end else if (wbm_adr_o != t.adr || wbm_we_o != t.we || wbm_sel_o != t.sel ||
                             wbm_dat_o != t.dat || wbm_stb_o != 1'b1) begin
                    t.stable = 1'b0;
                end
                wcnt++;
                if (!no_ack && wcnt >= lat) begin
                    r = $urandom();
                    if (!t.we && t.adr == A_RX) begin
                        b = (rxq.size() > 0) ? rxq.pop_front() : 8'($urandom());
                        r[7:0] = b;
                        rx_exp.push_back(b);
                    end else if (!t.we && t.adr == A_STAT) begin
                        r[BUSY_BIT] = (busy_left > 0);
                        if (busy_left > 0) busy_left--;
                    end else if (t.we && t.adr == A_TX) begin
                        busy_left = rand_busy ? int'($urandom_range(0, 2)) : busy_next;
                    end
                    wbm_dat_i = r;
                    wbm_ack_i = 1'b1;
                    log_q.push_back(t);
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; irq_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = '0; rx_ready_i = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        rxq.delete(); rx_exp.delete(); log_q.delete(); busy_left = 0;
    endtask

    task automatic pulse_irq();
        irq_i = 1'b1; tick(1); irq_i = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        int k = 0;
        while (log_q.size() < n && k < budget) begin tick(1); k++; end
        ok = (log_q.size() >= n);
    endtask

    task automatic wait_tx_ready(input int budget);
        int k = 0;
        while (!tx_ready_o && k < budget) begin tick(1); k++; end
    endtask

    task automatic send_tx(input logic [7:0] b);
        wait_tx_ready(2000);
        chk("tx_ready_before", tx_ready_o, 1);
        tx_valid_i = 1'b1; tx_data_i = b;
        tick(1);
        tx_valid_i = 1'b0;
        chk("tx_ready_after_accept", tx_ready_o, 0);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        int k = 0;
        while (!rx_valid_o && k < 300) begin tick(1); k++; end
        chk({name, "_valid"}, rx_valid_o, 1);
        chk(name, rx_data_o, exp);
        rx_ready_i = 1'b1; tick(1); rx_ready_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[4];
        logic [7:0] bytes5[5];
        int         base;
        bit         ok;
        int         len;
        int         k;

        rst_n = 1'b0;
        do_reset();

        // Reset state.
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_tx_ready", tx_ready_o, 1);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_err", err_o, 0);

        // Single irq read.
        base = log_q.size();
        rxq.push_back(8'hA5);
        pulse_irq();
        wait_log(base + 1, 50, ok);
        chk("irq_read_seen", ok, 1);
        if (ok) begin
            chk("irq_read_adr", log_q[base].adr, A_RX);
            chk("irq_read_we", log_q[base].we, 0);
            chk("irq_read_sel", log_q[base].sel, 4'hF);
            chk("irq_read_stable", log_q[base].stable, 1);
        end
        tick(20);
        chk("irq_read_count", log_q.size() - base, 1);
        pop_check("rx_a5", 8'hA5);

        // Table of TX bytes with busy poll counts, each followed by an RX read.
        vecs[0] = '{tx: 8'h3C, busy: 2, rx: 8'h11};
        vecs[1] = '{tx: 8'h00, busy: 0, rx: 8'hFF};
        vecs[2] = '{tx: 8'hFF, busy: 1, rx: 8'h5A};
        vecs[3] = '{tx: 8'h81, busy: 3, rx: 8'hC3};
        for (int v = 0; v < 4; v++) begin
            base = log_q.size();
            busy_next = vecs[v].busy;
            send_tx(vecs[v].tx);
            tick(1);
            wait_tx_ready(2000);
            chk("tx_done_ready", tx_ready_o, 1);
            chk("tx_txn_count", log_q.size() - base, vecs[v].busy + 2);
            if (log_q.size() >= base + vecs[v].busy + 2) begin
                chk("tx_wr_adr", log_q[base].adr, A_TX);
                chk("tx_wr_we", log_q[base].we, 1);
                chk("tx_wr_sel", log_q[base].sel, 4'h1);
                chk("tx_wr_dat", log_q[base].dat, {24'h0, vecs[v].tx});
                for (int p = 1; p <= vecs[v].busy + 1; p++) begin
                    chk("poll_adr", log_q[base + p].adr, A_STAT);
                    chk("poll_we", log_q[base + p].we, 0);
                    chk("poll_stable", log_q[base + p].stable, 1);
                    if (p > 1) begin
                        chk("poll_spacing",
                            (log_q[base + p].start - log_q[base + p - 1].start) >= 16, 1);
                    end
                end
            end
            rxq.push_back(vecs[v].rx);
            pulse_irq();
            pop_check("rx_table", vecs[v].rx);
        end

        // RX buffer full: fifth read waits for a pop, order is kept.
        base = log_q.size();
        for (int i = 0; i < 5; i++) begin
            bytes5[i] = 8'($urandom());
            rxq.push_back(bytes5[i]);
        end
        for (int i = 0; i < 5; i++) begin
            pulse_irq();
            wait_log(base + i + 1, 40, ok);
        end
        tick(30);
        chk("full_read_count", log_q.size() - base, 4);
        chk("full_rx_valid", rx_valid_o, 1);
        pop_check("rx_order0", bytes5[0]);
        wait_log(base + 5, 60, ok);
        chk("read_after_pop", ok, 1);
        for (int i = 1; i < 5; i++) pop_check("rx_order", bytes5[i]);

        // Ack timeout on an RX read.
        no_ack = 1'b1;
        base = log_q.size();
        pulse_irq();
        k = 0;
        while (!wbm_cyc_o && k < 20) begin tick(1); k++; end
        chk("tmo_cyc_rise", wbm_cyc_o, 1);
        len = 0;
        while (wbm_cyc_o && len < 400) begin tick(1); len++; end
        chk("tmo_cyc_len", len, 255);
        chk("tmo_err", err_o, 1);
        chk("tmo_no_push", rx_valid_o, 0);
        no_ack = 1'b0;
        tick(20);
        chk("tmo_no_retry", log_q.size() - base, 0);
        rxq.push_back(8'h77);
        pulse_irq();
        pop_check("rx_after_tmo", 8'h77);
        chk("err_sticky", err_o, 1);

        // Ack timeout on a TX write frees the holding register.
        no_ack = 1'b1;
        send_tx(8'h66);
        wait_tx_ready(600);
        chk("tx_tmo_freed", tx_ready_o, 1);
        no_ack = 1'b0;
        tick(5);

        // irq and TX in the same cycle: RX read goes first.
        base = log_q.size();
        busy_next = 0;
        rxq.push_back(8'h42);
        irq_i = 1'b1; tx_valid_i = 1'b1; tx_data_i = 8'h99;
        tick(1);
        irq_i = 1'b0; tx_valid_i = 1'b0;
        wait_log(base + 3, 300, ok);
        chk("both_seen", ok, 1);
        if (ok) begin
            chk("both_first_rx", log_q[base].adr, A_RX);
            chk("both_then_tx", log_q[base + 1].adr, A_TX);
            chk("both_tx_dat", log_q[base + 1].dat, 32'h99);
        end
        pop_check("rx_both", 8'h42);

        // Reset in the middle of a TX write, with an RX byte still buffered.
        rxq.push_back(8'h5A);
        pulse_irq();
        k = 0;
        while (!rx_valid_o && k < 50) begin tick(1); k++; end
        ack_delay = 30;
        send_tx(8'h55);
        k = 0;
        while (!wbm_cyc_o && k < 30) begin tick(1); k++; end
        chk("mid_wr_cyc", wbm_cyc_o, 1);
        chk("mid_wr_adr", wbm_adr_o, A_TX);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", wbm_cyc_o, 0);
        chk("async_rst_stb", wbm_stb_o, 0);
        chk("async_rst_rx_valid", rx_valid_o, 0);
        chk("async_rst_tx_ready", tx_ready_o, 1);
        chk("async_rst_err", err_o, 0);
        tick(2);
        rst_n = 1'b1;
        ack_delay = 2;
        rxq.delete(); rx_exp.delete();
        base = log_q.size();
        tick(30);
        chk("after_rst_quiet", log_q.size() - base, 0);
        chk("after_rst_cyc", wbm_cyc_o, 0);

        // Randomized traffic against byte-order queues.
        do_reset();
        rand_busy = 1'b1;
        rand_lat  = 1'b1;
        tx_exp.delete();
        base = log_q.size();
        for (int c = 0; c < 5000; c++) begin
            bit acc;
            acc = 1'b0;
            if (c < 3000) begin
                irq_i = ($urandom_range(0, 29) == 0);
                rx_ready_i = 1'($urandom_range(0, 1));
                if (!tx_valid_i && $urandom_range(0, 19) == 0) begin
                    tx_valid_i = 1'b1;
                    tx_data_i  = 8'($urandom());
                end
            end else begin
                irq_i = 1'b0;
                rx_ready_i = 1'b1;
            end
            if (tx_valid_i && tx_ready_o) begin
                tx_exp.push_back(tx_data_i);
                acc = 1'b1;
            end
            if (rx_valid_o && rx_ready_i) begin
                chk("rand_rx_avail", rx_exp.size() > 0, 1);
                if (rx_exp.size() > 0) chk("rand_rx", rx_data_o, rx_exp.pop_front());
            end
            tick(1);
            if (acc) tx_valid_i = 1'b0;
        end
        rx_ready_i = 1'b0;
        k = 0;
        len = 0;
        for (int i = base; i < log_q.size(); i++) begin
            if (!log_q[i].stable) len++;
            if (log_q[i].we) begin
                chk("rand_tx_dat", log_q[i].dat,
                    (k < tx_exp.size()) ? {24'h0, tx_exp[k]} : 32'hFFFF_FFFF);
                k++;
                if (i + 1 < log_q.size()) chk("rand_after_wr", log_q[i + 1].adr, A_STAT);
            end
        end
        chk("rand_tx_count", k, tx_exp.size());
        chk("rand_rx_drained", rx_exp.size(), 0);
        chk("rand_bus_stable", len, 0);
        chk("rand_tx_ready", tx_ready_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
